// File: rtl/axi_hp_wr_sched_pkg.sv
// Shared AXI3 constants and FSM encoding for the HP0 write scheduler.
package axi_hp_pkg;

    localparam logic [2:0] SIZE_4B          = 3'b010;
    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLVERR      = 2'b10;
    localparam logic [3:0] WSTRB_ALL        = 4'hF;
    localparam logic [3:0] CACHE_BUFFERABLE = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } wr_state_e;

    // A burst is unusable if it is not word aligned or its last byte lies past the 4KB page.
    function automatic logic burst_illegal(input logic [31:0] addr, input logic [3:0] len);
        logic [5:0]  beats;
        logic [12:0] end_off;
        beats   = {2'b00, len} + 6'd1;
        end_off = {1'b0, addr[11:0]} + {5'd0, beats, 2'b00};
        return (end_off > 13'd4096) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/axi_hp_wr_sched_if.sv
// AXI3 write-only channel bundle (AW/W/B) between the scheduler and the PS7 HP slave port.
interface axi_hp_wr_sched_if #(
    parameter int unsigned IDW = 6
) ();

    logic [31:0]    awaddr;
    logic [3:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic [IDW-1:0] awid;
    logic [3:0]     awcache;
    logic [2:0]     awprot;
    logic [3:0]     awqos;
    logic [1:0]     awlock;
    logic           awvalid;
    logic           awready;

    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic [IDW-1:0] wid;
    logic           wlast;
    logic           wvalid;
    logic           wready;

    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awcache, awprot, awqos, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wid, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awcache, awprot, awqos, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wid, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_hp_wr_sched_rr_arb.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int unsigned k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/axi_hp_wr_sched.sv
// Round-robin scheduler sharing one AXI3 HP write port between NREQ burst writers,
// one burst in flight at a time.
module axi_hp_wr_sched
    import axi_hp_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 6
) (
    input  logic                 AXI_clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [4*NREQ-1:0]    req_len,
    output logic [NREQ-1:0]      req_ack,
    input  logic [32*NREQ-1:0]   s_wdata,
    input  logic [NREQ-1:0]      s_wvalid,
    output logic [NREQ-1:0]      s_wready,
    output logic [NREQ-1:0]      done,
    output logic [1:0]           done_resp,
    axi_hp_wr_sched_if.master    axi
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wr_state_e       state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [31:0]     sel_addr;
    logic [3:0]      sel_len;
    logic [31:0]     sel_wdata;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = req_addr[32*i +: 32];
                sel_len  = req_len[4*i +: 4];
            end
            if (i == 32'(idx_q)) begin
                sel_wdata = s_wdata[32*i +: 32];
            end
        end
    end

    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = SIZE_4B;
    assign axi.awburst = BURST_INCR;
    assign axi.awid    = IDW'(idx_q);
    assign axi.awcache = CACHE_BUFFERABLE;
    assign axi.awprot  = '0;
    assign axi.awqos   = '0;
    assign axi.awlock  = '0;
    assign axi.wdata   = sel_wdata;
    assign axi.wstrb   = WSTRB_ALL;
    assign axi.wid     = IDW'(idx_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        req_ack     = '0;
        done        = '0;
        done_resp   = RESP_OKAY;
        s_wready    = '0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Decisions are held off while reset is asserted so outputs stay quiet.
                if (arb_any && !rst) begin
                    idx_d  = arb_idx;
                    gnt_d  = arb_gnt;
                    addr_d = sel_addr;
                    len_d  = sel_len;
                    if (burst_illegal(sel_addr, sel_len)) begin
                        req_ack   = arb_gnt;
                        done      = arb_gnt;
                        done_resp = RESP_SLVERR;
                        ptr_d     = wrap_inc(arb_idx);
                    end else begin
                        state_d = ST_AW;
                    end
                end
            end
            ST_AW: begin
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    req_ack = gnt_q;
                    cnt_d   = '0;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                axi.wvalid = |(s_wvalid & gnt_q);
                axi.wlast  = (cnt_q == len_q);
                s_wready   = gnt_q & {NREQ{axi.wready}};
                if (axi.wvalid && axi.wready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (axi.wlast) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    done      = gnt_q;
                    done_resp = (axi.bid == IDW'(idx_q)) ? axi.bresp : RESP_SLVERR;
                    ptr_d     = wrap_inc(idx_q);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_hp_wr_sched.sv
// Directed scoreboard bench for axi_hp_wr_sched with a reactive AXI slave and requester data sources.
module tb_axi_hp_wr_sched;
    import axi_hp_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [32*NREQ-1:0]   req_addr  = '0;
    logic [4*NREQ-1:0]    req_len   = '0;
    logic [NREQ-1:0]      req_ack;
    logic [32*NREQ-1:0]   s_wdata   = '0;
    logic [NREQ-1:0]      s_wvalid  = '0;
    logic [NREQ-1:0]      s_wready;
    logic [NREQ-1:0]      done;
    logic [1:0]           done_resp;

    axi_hp_wr_sched_if #(.IDW(IDW)) axi ();

    axi_hp_wr_sched #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .AXI_clk   (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ack   (req_ack),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .done      (done),
        .done_resp (done_resp),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]    addr;
        logic [3:0]     len;
        logic [IDW-1:0] id;
    } aw_t;

    typedef struct packed {
        logic [NREQ-1:0] onehot;
        logic [1:0]      resp;
        logic            rej;
    } done_t;

    aw_t         aw_exp[$];
    logic [31:0] w_exp[$];
    done_t       done_exp[$];
    int unsigned ack_exp[$];

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned exp_next[NREQ]   = '{default: 0};
    int unsigned dcnt[NREQ]       = '{default: 0};
    int unsigned acks_seen[NREQ]  = '{default: 0};
    int unsigned done_seen  = 0;
    int unsigned beats_seen = 0;
    int unsigned aw_delay   = 0;
    logic        w_toggle   = 1'b0;
    logic [1:0]  b_resp     = 2'b00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_word(input int unsigned i, input int unsigned n);
        return {8'(i), 24'(n)};
    endfunction

    task automatic set_req(input int unsigned i, input logic [31:0] a, input logic [3:0] l);
        req_addr[32*i +: 32] = a;
        req_len[4*i +: 4]    = l;
    endtask

    task automatic push_ok(input int unsigned i, input logic [31:0] a, input logic [3:0] l,
                           input logic [1:0] resp);
        aw_t   e;
        done_t d;
        e.addr = a;
        e.len  = l;
        e.id   = IDW'(i);
        aw_exp.push_back(e);
        ack_exp.push_back(i);
        for (int unsigned b = 0; b <= 32'(l); b++) begin
            w_exp.push_back(beat_word(i, exp_next[i]));
            exp_next[i]++;
        end
        d.onehot = NREQ'(1) << i;
        d.resp   = resp;
        d.rej    = 1'b0;
        done_exp.push_back(d);
    endtask

    task automatic issue(input int unsigned i, input logic [31:0] a, input logic [3:0] l,
                         input logic [1:0] resp);
        int unsigned b0;
        int unsigned t;
        b0 = acks_seen[i];
        t  = 0;
        push_ok(i, a, l, resp);
        set_req(i, a, l);
        req_valid[i] = 1'b1;
        while (acks_seen[i] == b0 && t < 200) begin
            @(negedge clk); #2;
            t++;
        end
        req_valid[i] = 1'b0;
        check("ack_seen", 64'(acks_seen[i] != b0), 64'd1);
    endtask

    task automatic reject(input int unsigned i, input logic [31:0] a, input logic [3:0] l);
        done_t       d;
        int unsigned base;
        d.onehot = NREQ'(1) << i;
        d.resp   = RESP_SLVERR;
        d.rej    = 1'b1;
        done_exp.push_back(d);
        base = done_seen;
        @(negedge clk);
        set_req(i, a, l);
        req_valid[i] = 1'b1;
        @(negedge clk);
        req_valid[i] = 1'b0;
        check("reject_done_count", 64'(done_seen), 64'(base + 1));
    endtask

    task automatic wait_done(input int unsigned n, input string tag);
        int unsigned t;
        t = 0;
        while (done_seen < n && t < 400) begin
            @(negedge clk); #2;
            t++;
        end
        check({tag, "_done"}, 64'(done_seen >= n), 64'd1);
    endtask

    // Reactive slave and requester data sources: drive on negedge, observe 1 time unit later.
    initial begin : slave
        aw_t            e;
        done_t          d;
        logic [31:0]    aw_hold;
        logic [IDW-1:0] cur_id;
        logic [3:0]     cur_len;
        int unsigned    beat;
        int unsigned    aw_wait;
        int unsigned    ai;
        logic           b_pend;
        logic [31:0]    wexp;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bid     = '0;
        axi.bresp   = '0;
        aw_hold = '0; cur_id = '0; cur_len = '0; beat = 0; aw_wait = 0; b_pend = 1'b0;
        forever begin
            @(negedge clk);
            for (int unsigned i = 0; i < NREQ; i++) s_wdata[32*i +: 32] = beat_word(i, dcnt[i]);
            s_wvalid = '1;
            if (rst) begin
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                beat = 0; aw_wait = 0; b_pend = 1'b0;
            end else begin
                axi.awready = (aw_wait >= aw_delay);
                axi.wready  = w_toggle ? ~axi.wready : 1'b1;
                axi.bvalid  = b_pend;
                axi.bid     = cur_id;
                axi.bresp   = b_resp;
            end
            #1;
            if (axi.awvalid && !axi.awready) begin
                if (aw_wait > 0) check("awaddr_stable", 64'(axi.awaddr), 64'(aw_hold));
                aw_hold = axi.awaddr;
                aw_wait++;
            end
            if (axi.awvalid && axi.awready) begin
                check("aw_expected", 64'(aw_exp.size() != 0), 64'd1);
                if (aw_exp.size() != 0) begin
                    e = aw_exp.pop_front();
                    check("awaddr", 64'(axi.awaddr), 64'(e.addr));
                    check("awlen", 64'(axi.awlen), 64'(e.len));
                    check("awid", 64'(axi.awid), 64'(e.id));
                    check("aw_consts", 64'({axi.awsize, axi.awburst, axi.awcache}),
                          64'({SIZE_4B, BURST_INCR, CACHE_BUFFERABLE}));
                end
                cur_id  = axi.awid;
                cur_len = axi.awlen;
                aw_wait = 0;
                beat    = 0;
            end
            if (axi.wvalid && axi.wready) begin
                check("w_expected", 64'(w_exp.size() != 0), 64'd1);
                wexp = (w_exp.size() != 0) ? w_exp.pop_front() : 32'hDEAD_BEEF;
                check("wdata", 64'(axi.wdata), 64'(wexp));
                check("wlast", 64'(axi.wlast), 64'(beat == 32'(cur_len)));
                check("wid_wstrb", 64'({axi.wid, axi.wstrb}), 64'({cur_id, 4'hF}));
                beats_seen++;
                if (axi.wlast) begin
                    b_pend = 1'b1;
                    beat   = 0;
                end else begin
                    beat++;
                end
            end
            if (s_wready != '0) check("s_wready_granted_only", 64'(s_wready), 64'(NREQ'(1) << cur_id));
            if (axi.bvalid && axi.bready) b_pend = 1'b0;
            if (done != '0) begin
                check("done_expected", 64'(done_exp.size() != 0), 64'd1);
                if (done_exp.size() != 0) begin
                    d = done_exp.pop_front();
                    check("done_idx", 64'(done), 64'(d.onehot));
                    check("done_resp", 64'(done_resp), 64'(d.resp));
                    if (d.rej) check("reject_ack_same_cycle", 64'(req_ack), 64'(d.onehot));
                end
                done_seen++;
            end
            if ((req_ack & ~done) != '0) begin
                check("ack_expected", 64'(ack_exp.size() != 0), 64'd1);
                if (ack_exp.size() != 0) begin
                    ai = ack_exp.pop_front();
                    check("ack_idx", 64'(req_ack), 64'(NREQ'(1) << ai));
                    acks_seen[ai]++;
                end
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (s_wready[i] && s_wvalid[i]) dcnt[i]++;
            end
        end
    end

    initial begin : main
        int unsigned base;
        int unsigned a0;
        int unsigned a1;
        int unsigned t;

        repeat (3) @(negedge clk);
        #2;
        check("reset_outputs",
              64'({axi.awvalid, axi.wvalid, axi.bready, done, req_ack, s_wready}), 64'd0);
        check("reset_state_ptr", 64'({dut.state_q, dut.ptr_q}), 64'({ST_IDLE, 1'b0}));
        rst = 1'b0;

        // 1: single 4-beat burst from requester 0
        base = done_seen;
        issue(0, 32'h1000_0000, 4'd3, RESP_OKAY);
        wait_done(base + 1, "t1");

        // 2: both requesters continuously valid -> strict alternation
        base = done_seen;
        a0 = acks_seen[0];
        a1 = acks_seen[1];
        push_ok(1, 32'h1000_1000, 4'd2, RESP_OKAY);
        push_ok(0, 32'h1000_0100, 4'd1, RESP_OKAY);
        push_ok(1, 32'h1000_1000, 4'd2, RESP_OKAY);
        push_ok(0, 32'h1000_0100, 4'd1, RESP_OKAY);
        set_req(0, 32'h1000_0100, 4'd1);
        set_req(1, 32'h1000_1000, 4'd2);
        req_valid = 2'b11;
        t = 0;
        while (req_valid != '0 && t < 600) begin
            @(negedge clk); #2;
            t++;
            if (acks_seen[0] >= a0 + 2) req_valid[0] = 1'b0;
            if (acks_seen[1] >= a1 + 2) req_valid[1] = 1'b0;
        end
        req_valid = '0;
        wait_done(base + 4, "t2");

        // 3: 4KB crossing rejected, exact page end accepted (len=0), misaligned rejected
        reject(1, 32'h1000_0FF0, 4'd7);
        base = done_seen;
        issue(0, 32'h1000_0FFC, 4'd0, RESP_OKAY);
        wait_done(base + 1, "t3b");
        reject(1, 32'h1000_0002, 4'd0);

        // 4: awready stalled 5 cycles, wready toggling
        aw_delay = 5;
        w_toggle = 1'b1;
        base = done_seen;
        issue(0, 32'h1000_2000, 4'd5, RESP_OKAY);
        wait_done(base + 1, "t4");
        aw_delay = 0;
        w_toggle = 1'b0;

        // 5: reset after two beats of a requester-1 burst
        @(negedge clk); #2;
        check("t5_ptr_before", 64'(dut.ptr_q), 64'd1);
        base = beats_seen;
        issue(1, 32'h1000_3000, 4'd3, RESP_OKAY);
        t = 0;
        while (beats_seen < base + 2 && t < 100) begin
            @(negedge clk); #2;
            t++;
        end
        check("t5_two_beats", 64'(beats_seen), 64'(base + 2));
        rst = 1'b1;
        @(negedge clk); #2;
        check("t5_reset_outputs", 64'({axi.awvalid, axi.wvalid, axi.bready, s_wready}), 64'd0);
        check("t5_reset_state_ptr", 64'({dut.state_q, dut.ptr_q}), 64'({ST_IDLE, 1'b0}));
        w_exp.delete();
        done_exp.delete();
        exp_next[1] = exp_next[1] - 2;
        @(negedge clk);
        rst = 1'b0;

        // 6: slave returns SLVERR; pointer still advances
        b_resp = RESP_SLVERR;
        base = done_seen;
        issue(0, 32'h1000_4000, 4'd2, RESP_SLVERR);
        wait_done(base + 1, "t6");
        @(negedge clk); #2;
        check("t6_ptr_advanced", 64'(dut.ptr_q), 64'd1);
        b_resp = RESP_OKAY;

        repeat (3) @(negedge clk);
        check("queues_drained",
              64'({16'(aw_exp.size()), 16'(w_exp.size()), 16'(done_exp.size()), 16'(ack_exp.size())}),
              64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
